// File: rtl/param_snapshot_tx.sv
// Source-side end of the effect-parameter crossing into the pixel domain.
// It captures the packed bus, holds it while a toggle request/ack handshake completes, and defers any new changes until the handshake is done.
module param_snapshot_tx #(
    parameter int unsigned DATA_W         = 139,
    parameter int unsigned MIN_HOLD       = 4,
    parameter int unsigned REFRESH_CYCLES = 1048576,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              force_send,
    input  logic              ack_tgl_async,
    output logic [DATA_W-1:0] data_out,
    output logic              req_tgl,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       update_count
);

    localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int unsigned UPD_W  = 16;

    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
    localparam logic              REF_EN    = (REFRESH_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t              r_state,        w_state_nx;
    logic [DATA_W-1:0]   r_data_out,     w_data_out_nx;
    logic                r_req_tgl,      w_req_tgl_nx;
    logic                r_busy,         w_busy_nx;
    logic                r_timeout_err,  w_timeout_err_nx;
    logic [UPD_W-1:0]    r_update_count, w_update_count_nx;
    logic                r_pending,      w_pending_nx;
    logic [REF_W-1:0]    r_ref_cnt,      w_ref_cnt_nx;
    logic [HOLD_W-1:0]   r_hold_cnt,     w_hold_cnt_nx;
    logic [TO_W-1:0]     r_to_cnt,       w_to_cnt_nx;
    logic                r_ack_s1;
    logic                r_ack_s2;

    logic                w_changed;
    logic                w_refresh_hit;
    logic                w_trig;
    logic                w_ack_seen;

    assign w_changed     = (data_in != r_data_out);
    assign w_refresh_hit = REF_EN && (r_ref_cnt == REF_LAST);
    assign w_trig        = w_changed | r_pending | force_send | w_refresh_hit;
    assign w_ack_seen    = (r_ack_s2 == r_req_tgl);

    // Two-flop synchroniser for the returning acknowledge toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_ack_s1 <= ack_tgl_async;
            r_ack_s2 <= r_ack_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_data_out     <= '0;
            r_req_tgl      <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_update_count <= '0;
            r_pending      <= 1'b0;
            r_ref_cnt      <= '0;
            r_hold_cnt     <= '0;
            r_to_cnt       <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_data_out     <= w_data_out_nx;
            r_req_tgl      <= w_req_tgl_nx;
            r_busy         <= w_busy_nx;
            r_timeout_err  <= w_timeout_err_nx;
            r_update_count <= w_update_count_nx;
            r_pending      <= w_pending_nx;
            r_ref_cnt      <= w_ref_cnt_nx;
            r_hold_cnt     <= w_hold_cnt_nx;
            r_to_cnt       <= w_to_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx        = r_state;
        w_data_out_nx     = r_data_out;
        w_req_tgl_nx      = r_req_tgl;
        w_busy_nx         = r_busy;
        w_timeout_err_nx  = r_timeout_err;
        w_update_count_nx = r_update_count;
        w_pending_nx      = r_pending;
        w_ref_cnt_nx      = r_ref_cnt;
        w_hold_cnt_nx     = r_hold_cnt;
        w_to_cnt_nx       = r_to_cnt;

        // Changes seen mid-transfer are remembered so the latest value goes out after HOLD.
        if ((r_state != S_IDLE) && (w_changed || force_send)) begin
            w_pending_nx = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_ref_cnt_nx = r_ref_cnt + REF_W'(1);
                if (w_trig) begin
                    w_data_out_nx = data_in;
                    w_req_tgl_nx  = ~r_req_tgl;
                    w_busy_nx     = 1'b1;
                    w_to_cnt_nx   = '0;
                    w_ref_cnt_nx  = '0;
                    w_pending_nx  = 1'b0;
                    w_state_nx    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // An ack in the saturating cycle takes priority over the timeout.
                if (w_ack_seen) begin
                    w_update_count_nx = r_update_count + UPD_W'(1);
                    w_hold_cnt_nx     = HOLD_LOAD;
                    w_state_nx        = S_HOLD;
                end else if (r_to_cnt == TO_MAX) begin
                    w_timeout_err_nx = 1'b1;
                end else begin
                    w_to_cnt_nx = r_to_cnt + TO_W'(1);
                    if ((r_to_cnt + TO_W'(1)) == TO_MAX) begin
                        w_timeout_err_nx = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_hold_cnt_nx = r_hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign data_out     = r_data_out;
    assign req_tgl      = r_req_tgl;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;
    assign update_count = r_update_count;

endmodule

// File: tb/tb_param_snapshot_tx.sv
// Bench for param_snapshot_tx: directed protocol steps followed by a randomized phase
// checked by a snapshot scoreboard, with the bench acting as the pixel-domain receiver.
module tb_param_snapshot_tx;

    localparam int unsigned DATA_W  = 139;
    localparam int unsigned HOLD    = 4;
    localparam int unsigned REFRESH = 8;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              force_send;
    logic              ack_tgl_async;
    logic [DATA_W-1:0] data_out;
    logic              req_tgl;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       update_count;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_data;
    logic              exp_req;
    int                exp_upd;

    param_snapshot_tx #(
        .DATA_W         (DATA_W),
        .MIN_HOLD       (HOLD),
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .force_send    (force_send),
        .ack_tgl_async (ack_tgl_async),
        .data_out      (data_out),
        .req_tgl       (req_tgl),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .update_count  (update_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_busy);
        chk_d({tag, ".data"}, data_out, exp_data);
        chk_b({tag, ".req"}, req_tgl, exp_req);
        chk_b({tag, ".busy"}, busy, exp_busy);
        chk_n({tag, ".upd"}, update_count, 16'(exp_upd));
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    // Receiver returns the toggle now: 2 sync cycles, +1 to reach HOLD, then HOLD cycles.
    task automatic ack_and_hold(input string tag);
        ack_tgl_async = exp_req;
        repeat (2) tick();
        chk_all({tag, ".sync"}, 1'b1);
        tick();
        exp_upd++;
        chk_all({tag, ".ack"}, 1'b1);
        repeat (HOLD - 1) tick();
        chk_b({tag, ".hold_busy"}, busy, 1'b1);
        tick();
        chk_all({tag, ".idle"}, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] a, b, c, d, e;
        logic [DATA_W-1:0] prev_din;
        int                rx_cnt;
        int                acks;

        rst_n         = 1'b0;
        data_in       = '0;
        force_send    = 1'b0;
        ack_tgl_async = 1'b0;
        exp_data      = '0;
        exp_req       = 1'b0;
        exp_upd       = 0;

        #3;
        chk_all("reset", 1'b0);
        chk_b("reset.err", timeout_err, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Unchanged zero bus: only the refresh timer causes a send.
        repeat (REFRESH - 1) tick();
        chk_all("refresh.pre", 1'b0);
        tick();
        exp_req = 1'b1;
        chk_all("refresh.cap", 1'b1);
        ack_and_hold("refresh");

        data_in = DATA_W'(12'h155);
        tick();
        exp_data = DATA_W'(12'h155);
        exp_req  = ~exp_req;
        chk_all("d155.cap", 1'b1);
        ack_and_hold("d155");

        // Three changes while waiting: only the last is sent after HOLD.
        a = rand_data(); b = rand_data(); c = rand_data();
        data_in = a;
        tick();
        exp_data = a;
        exp_req  = ~exp_req;
        chk_all("abc.cap_a", 1'b1);
        data_in = b;
        tick();
        chk_all("abc.b", 1'b1);
        data_in = c;
        tick();
        chk_all("abc.c", 1'b1);
        ack_and_hold("abc");
        tick();
        exp_data = c;
        exp_req  = ~exp_req;
        chk_all("abc.cap_c", 1'b1);
        ack_and_hold("abc2");
        repeat (3) tick();
        chk_all("abc.quiet", 1'b0);

        // No acknowledge: timeout after TIMEOUT wait cycles, no re-toggle, late ack still accepted.
        d = rand_data();
        data_in = d;
        tick();
        exp_data = d;
        exp_req  = ~exp_req;
        chk_all("to.cap", 1'b1);
        repeat (TIMEOUT - 1) tick();
        chk_b("to.pre", timeout_err, 1'b0);
        tick();
        chk_b("to.set", timeout_err, 1'b1);
        repeat (10) tick();
        chk_all("to.noretgl", 1'b1);
        ack_and_hold("to.late");
        chk_b("to.sticky", timeout_err, 1'b1);

        // force_send with unchanged data in IDLE, then again during HOLD.
        force_send = 1'b1;
        tick();
        force_send = 1'b0;
        exp_req = ~exp_req;
        chk_all("force.cap", 1'b1);
        ack_tgl_async = exp_req;
        repeat (3) tick();
        exp_upd++;
        chk_all("force.hold", 1'b1);
        force_send = 1'b1;
        tick();
        force_send = 1'b0;
        repeat (HOLD - 1) tick();
        chk_all("force.idle", 1'b0);
        tick();
        exp_req = ~exp_req;
        chk_all("force.resend", 1'b1);
        ack_and_hold("force2");
        repeat (3) tick();
        chk_all("force.quiet", 1'b0);

        // force_send coinciding with a data change: a single capture.
        e = rand_data();
        data_in    = e;
        force_send = 1'b1;
        tick();
        force_send = 1'b0;
        exp_data = e;
        exp_req  = ~exp_req;
        chk_all("both.cap", 1'b1);
        ack_and_hold("both");
        repeat (3) tick();
        chk_all("both.quiet", 1'b0);

        // Randomized traffic; receiver answers after a random delay, then goes silent.
        prev_din = data_in;
        rx_cnt   = 0;
        acks     = 0;
        for (int i = 0; i < 560; i++) begin
            tick();
            if (req_tgl !== exp_req) begin
                exp_req  = ~exp_req;
                exp_data = prev_din;
                chk_b("rnd.prior_acked", ack_tgl_async, ~exp_req);
            end
            chk_d("rnd.data", data_out, exp_data);
            if (i < 548) begin
                if (rx_cnt > 0) begin
                    rx_cnt--;
                    if (rx_cnt == 0) begin
                        ack_tgl_async = exp_req;
                        acks++;
                    end
                end else if (ack_tgl_async !== exp_req) begin
                    rx_cnt = int'($urandom_range(4, 1));
                end
            end
            force_send = 1'b0;
            if (i < 500) begin
                if (($urandom % 4) == 0) data_in = rand_data();
                force_send = (($urandom % 16) == 0);
            end
            prev_din = data_in;
        end
        exp_upd += acks;
        chk_n("rnd.upd", update_count, 16'(exp_upd));
        chk_d("rnd.final", data_out, data_in);

        // Asynchronous reset in the middle of a wait, then a stale ack toggle.
        for (int k = 0; k < 20 && !busy; k++) tick();
        chk_b("rst.busy_pre", busy, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_data = '0;
        exp_req  = 1'b0;
        exp_upd  = 0;
        chk_all("rst.async", 1'b0);
        chk_b("rst.err", timeout_err, 1'b0);
        data_in       = '0;
        ack_tgl_async = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ack_tgl_async = 1'b1;
        repeat (REFRESH - 2) tick();
        chk_all("rst.stale", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_snapshot_tx.md
Name: param_snapshot_tx

Overview:
- Source-side (clk-domain) end of the parameter crossing into the pixel domain.
- Captures the packed effect-parameter bus into a snapshot register and holds it stable while the receiver samples it.
- Publishes each snapshot with a toggle request and waits for a toggle acknowledge returned from the receiving domain.
- Only one snapshot is in flight at a time, so the multi-bit bus is never sampled while it is changing.

Parameters:
- DATA_W, 139, width of the packed bus: 12 x 10-bit knobs, 6 x 3-bit source selects, 1 delay_rate_fast bit.
- MIN_HOLD, 4, clk cycles the snapshot stays frozen after an acknowledge before the next capture is allowed (must be >= 1).
- REFRESH_CYCLES, 1048576, idle cycles after which an unchanged snapshot is re-sent (0 disables refresh).
- TIMEOUT_CYCLES, 65535, clk cycles spent waiting for an acknowledge before timeout_err sets.

Ports:
- clk  input  1  source-domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  live packed parameter bus, clk domain.
- force_send  input  1  one-cycle pulse requesting a send even if data_in is unchanged.
- ack_tgl_async  input  1  acknowledge toggle from the pixel domain; unsynchronised.
- data_out  output  DATA_W  held snapshot; changes only on a capture cycle.
- req_tgl  output  1  request toggle; flips once per published snapshot.
- busy  output  1  high in WAIT_ACK and HOLD.
- timeout_err  output  1  sticky; set on acknowledge timeout.
- update_count  output  16  count of acknowledged snapshots; wraps at 16 bits.

Behaviour:
- Reset (rst_n low, asynchronous): the following all clear to 0 and the FSM goes to IDLE:
  - data_out, req_tgl, busy, timeout_err, update_count;
  - the 2-flop ack synchroniser (ack_s1, ack_s2);
  - the pending flag, refresh counter, hold counter and timeout counter.
- Ack synchroniser: ack_s1 <= ack_tgl_async, then ack_s2 <= ack_s1. Only ack_s2 is used. An acknowledge is seen when ack_s2 == req_tgl while in WAIT_ACK.
- Send trigger, evaluated in IDLE: trig = (data_in != data_out) | pending | force_send | refresh_hit.
  - refresh_hit = (REFRESH_CYCLES != 0) & (refresh counter == REFRESH_CYCLES-1).
- Pending flag:
  - Set in any non-IDLE state when data_in != data_out or force_send is high.
  - Cleared on a capture.
  - Changes during a transfer are therefore deferred, never lost; only the latest data_in is sent.
- FSM IDLE:
  - Refresh counter increments each cycle and clears on capture.
  - When trig is high, on that same edge: data_out <= data_in, req_tgl flips, busy goes high, timeout counter clears, next state is WAIT_ACK.
  - Capture latency from a data_in change is 1 cycle.
- FSM WAIT_ACK:
  - data_out is frozen.
  - On acknowledge: update_count increments, hold counter loads MIN_HOLD-1, next state is HOLD.
  - Otherwise the timeout counter increments, saturating. When it reaches TIMEOUT_CYCLES, timeout_err sets.
  - The block keeps waiting and never re-toggles req_tgl (a re-toggle would desynchronise the protocol).
  - timeout_err clears only on reset.
- FSM HOLD:
  - data_out is frozen.
  - The hold counter decrements. At 0, next state is IDLE and busy goes low.
  - A capture may then occur on the first IDLE cycle.
- Simultaneous events:
  - force_send in the same cycle as a data change: one capture only.
  - An acknowledge arriving in the cycle the timeout counter saturates: the acknowledge wins and timeout_err does not set.
- Round-trip latency: a data_in change gives req_tgl after 1 cycle; from the receiver's returned toggle to HOLD is 2 clk cycles of synchroniser plus 1.
- Reset mid-transfer:
  - req_tgl returns to 0. The receiver must also be reset, because the design shares one reset tree.
  - Any acknowledge toggle arriving after reset is ignored, since the FSM is in IDLE.
- Width rule: all comparisons are full DATA_W. update_count wraps from 65535 to 0.

Test Plan:
- Reset, then data_in=0 held -> no capture, req_tgl=0, busy=0. After REFRESH_CYCLES (set to 8 in the bench) -> capture with req_tgl=1.
- data_in changes to 0x155 in the low bits; ack loopback via 2 flops, MIN_HOLD=4 -> data_out=0x155 one cycle later; busy high until 3 cycles after the ack is seen, then 4 HOLD cycles; update_count=1.
- data_in changes 3 times (A, B, C) during WAIT_ACK -> data_out stays A until HOLD ends, then exactly one capture of C; update_count=2.
- Ack never returned, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles; req_tgl does not toggle again; a late ack -> HOLD, update_count increments, timeout_err stays 1.
- force_send pulse with unchanged data in IDLE -> one capture, req_tgl flips. force_send during HOLD -> pending, so exactly one extra send after HOLD.
- rst_n asserted mid-WAIT_ACK, asynchronously between edges -> all outputs 0 immediately. A stale ack toggle after release causes no state change.
